// File: rtl/simple_adapter_arb_pkg.sv
// Shared types and elaboration helpers for the packet round-robin adapter arbiter.
package simple_adapter_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_PAD  = 2'd2
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The downstream packer only flushes on whole words, so the beat ratio must be 2^k.
  function automatic bit ratio_ok(input int r);
    return (r >= 1) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/simple_adapter_arbiter_rr_arbiter.sv
// Round-robin pick: first requester strictly after last_ptr, wrapping; one-hot and encoded grant.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld
);

  logic [ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = ID_W'((int'(last_ptr) + i) % NUM_SRC);
      if (!gnt_vld && req[cand]) begin
        gnt_vld    = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_id     = cand;
      end
    end
  end

endmodule

// File: rtl/simple_adapter_arbiter.sv
// Packet round-robin arbiter in front of a narrow-to-wide adapter; pads packets to RATIO beats.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module simple_adapter_arbiter
  import simple_adapter_arb_pkg::*;
#(
  parameter int                   NUM_SRC     = 4,
  parameter int                   DIN_WIDTH   = 16,
  parameter int                   DOUT_WIDTH  = 128,
  parameter logic [DIN_WIDTH-1:0] PAD_VALUE   = '0,
  parameter int                   WDOG_CYCLES = 256,
  localparam int                  ID_W        = id_width(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_vld,
  input  logic [NUM_SRC-1:0]             src_last,
  input  logic [NUM_SRC*DIN_WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]             src_rdy,
  output logic                           dout_vld,
  output logic                           dout_last,
  output logic [DIN_WIDTH-1:0]           dout,
  output logic [ID_W-1:0]                dout_id,
  output logic                           busy,
  output logic                           err
);

  localparam int RATIO = DOUT_WIDTH / DIN_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("simple_adapter_arbiter: DOUT_WIDTH/DIN_WIDTH must be a power of two");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("simple_adapter_arbiter: WDOG_CYCLES must be at least 1");
  end

  arb_state_e           state_q, state_d;
  logic [NUM_SRC-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      id_q, id_d, ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_next;
  logic                 dout_vld_q, dout_vld_d, dout_last_q, dout_last_d;
  logic [DIN_WIDTH-1:0] dout_q, dout_d;
  logic [ID_W-1:0]      dout_id_q, dout_id_d;
  logic                 err_q, err_d;

  logic [NUM_SRC-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_vld;
  logic                 acc, cnt_last, wd_fire;
  logic [DIN_WIDTH-1:0] src_beat [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_beat[g] = src_data[g*DIN_WIDTH +: DIN_WIDTH];
  end

  rr_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_rr (
    .req      (src_vld),
    .last_ptr (ptr_q),
    .gnt      (arb_gnt),
    .gnt_id   (arb_id),
    .gnt_vld  (arb_vld)
  );

  assign src_rdy  = (state_q == ST_PASS) ? gnt_q : '0;
  assign acc      = (state_q == ST_PASS) && ((src_vld & gnt_q) != '0);
  assign cnt_last = (cnt_q == CNT_W'(RATIO - 1));
  assign cnt_next = cnt_last ? '0 : cnt_q + 1'b1;

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Counts consecutive granted-but-idle PASS cycles; anything else clears it.
  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if (state_q == ST_PASS && !acc) begin
      wd_d    = wd_q + 1'b1;
      wd_fire = (wd_d == WD_W'(WDOG_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_fire ? '0 : wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    dout_vld_d  = 1'b0;
    dout_last_d = 1'b0;
    dout_d      = '0;
    dout_id_d   = dout_id_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d = ST_PASS;
          gnt_d   = arb_gnt;
          id_d    = arb_id;
          ptr_d   = arb_id;
          cnt_d   = '0;
        end
      end
      ST_PASS: begin
        if (acc) begin
          dout_vld_d = 1'b1;
          dout_d     = src_beat[id_q];
          dout_id_d  = id_q;
          cnt_d      = cnt_next;
          if (src_last[id_q]) begin
            dout_last_d = cnt_last;
            state_d     = cnt_last ? ST_IDLE : ST_PAD;
            gnt_d       = '0;
          end
        end else if (wd_fire) begin
          err_d   = 1'b1;
          state_d = ST_PAD;
          gnt_d   = '0;
        end
      end
      ST_PAD: begin
        dout_vld_d  = 1'b1;
        dout_d      = PAD_VALUE;
        dout_id_d   = id_q;
        dout_last_d = cnt_last;
        cnt_d       = cnt_next;
        if (cnt_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      id_q        <= '0;
      ptr_q       <= ID_W'(NUM_SRC - 1);
      cnt_q       <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      dout_q      <= '0;
      dout_id_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      dout_vld_q  <= dout_vld_d;
      dout_last_q <= dout_last_d;
      dout_q      <= dout_d;
      dout_id_q   <= dout_id_d;
      err_q       <= err_d;
    end
  end

  assign dout_vld  = dout_vld_q;
  assign dout_last = dout_last_q;
  assign dout      = dout_q;
  assign dout_id   = dout_id_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_simple_adapter_arbiter.sv
// Scoreboard bench for simple_adapter_arbiter; watchdog scenario follows ARB_WATCHDOG_EN.
module tb_simple_adapter_arbiter;
  localparam int NS = 4;
  localparam int DW = 16;
  localparam int OW = 128;
  localparam int RATIO = OW / DW;
  localparam logic [15:0] PADV = 16'hA5A5;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  id;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0] src_vld, src_last, src_rdy;
  logic [NS*DW-1:0] src_data;
  logic dout_vld, dout_last, busy, err;
  logic [15:0] dout;
  logic [1:0] dout_id;

  logic tb_vld [NS];
  logic tb_last[NS];
  logic [15:0] tb_data[NS];

  beat_t exp_q[$];
  int gnt_order[$];
  int n_cmp = 0;
  int n_err = 0;

  simple_adapter_arbiter #(
    .NUM_SRC(NS), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .PAD_VALUE(PADV), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .src_vld(src_vld), .src_last(src_last), .src_data(src_data),
    .src_rdy(src_rdy), .dout_vld(dout_vld), .dout_last(dout_last), .dout(dout),
    .dout_id(dout_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_vld  = '0;
    src_last = '0;
    src_data = '0;
    for (int i = 0; i < NS; i++) begin
      src_vld[i] = tb_vld[i];
      src_last[i] = tb_last[i];
      src_data[i*DW +: DW] = tb_data[i];
    end
  end

  // Scoreboard: every output beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      n_cmp++;
      if (!$onehot0(src_rdy)) begin
        n_err++;
        $display("FAIL rdy_onehot got=%b required=one-hot-or-zero", src_rdy);
      end
      if (dout_vld === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat got data=%h id=%0d last=%b required=no beat", dout, dout_id, dout_last);
        end else begin
          e = exp_q.pop_front();
          if ({dout, dout_id, dout_last} !== {e.data, e.id, e.last}) begin
            n_err++;
            $display("FAIL scoreboard_beat got data=%h id=%0d last=%b required data=%h id=%0d last=%b",
                     dout, dout_id, dout_last, e.data, e.id, e.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic send_pkt(input int s, input int n, input logic [15:0] base, input bit lst,
                          input int stall_after, input int stall_len, output int lows);
    int pc;
    int waitc;
    bit acc;
    beat_t e;
    lows = 0;
    pc = 0;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      if (k == stall_after && stall_len > 0) begin
        tb_vld[s] = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          @(negedge clk);
          n_cmp++;
          if (src_rdy !== 4'(1 << s)) begin
            n_err++;
            $display("FAIL stall_rdy src=%0d got=%b required=%b", s, src_rdy, 4'(1 << s));
          end
          n_cmp++;
          if (err !== 1'b0) begin
            n_err++;
            $display("FAIL stall_err got=%b required=0", err);
          end
          if (j > 0 && dout_vld === 1'b0) lows++;
          @(posedge clk); #1;
        end
      end
      tb_vld[s]  = 1'b1;
      tb_data[s] = base + 16'(k);
      tb_last[s] = lst && (k == n - 1);
      acc = 1'b0;
      waitc = 0;
      while (!acc && waitc < 3000) begin
        @(negedge clk);
        if (src_rdy[s] === 1'b1) acc = 1'b1;
        else begin
          waitc++;
          @(posedge clk); #1;
        end
      end
      if (!acc) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout src=%0d beat=%0d got=no accept required=accept", s, k);
        tb_vld[s] = 1'b0;
        tb_last[s] = 1'b0;
        return;
      end
      if (k == 0) gnt_order.push_back(s);
      e.data = base + 16'(k);
      e.id   = 2'(s);
      e.last = tb_last[s] && ((pc + 1) % RATIO == 0);
      exp_q.push_back(e);
      pc++;
      if (tb_last[s]) begin
        while (pc % RATIO != 0) begin
          e.data = PADV;
          e.id   = 2'(s);
          e.last = ((pc + 1) % RATIO == 0);
          exp_q.push_back(e);
          pc++;
        end
      end
      @(posedge clk); #1;
    end
    tb_vld[s] = 1'b0;
    tb_last[s] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dout_vld, dout_last, dout, dout_id, err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got vld=%b last=%b dout=%h id=%0d err=%b required all zero",
               dout_vld, dout_last, dout, dout_id, err);
    end
    n_cmp++;
    if ({busy, src_rdy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_busy_rdy got busy=%b rdy=%b required 0", busy, src_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_packet();
    int l;
    send_pkt(1, 8, 16'h0001, 1'b1, -1, 0, l);
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL full_packet_drain got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_pad();
    int l;
    send_pkt(2, 1, 16'hABCD, 1'b1, -1, 0, l);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL pad_busy got=%b required=1", busy);
    end
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pad_drain got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int l0, l1, l2, l3;
    int exp_order[5];
    logic [43:0] got, expv;
    bit found;
    exp_order = '{0, 1, 2, 3, 0};
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    gnt_order.delete();
    got = '0;
    found = 1'b0;
    fork
      begin
        send_pkt(0, 2, 16'h3000, 1'b1, -1, 0, l0);
        send_pkt(0, 2, 16'h3010, 1'b1, -1, 0, l0);
      end
      send_pkt(1, 2, 16'h3100, 1'b1, -1, 0, l1);
      send_pkt(2, 2, 16'h3200, 1'b1, -1, 0, l2);
      send_pkt(3, 2, 16'h3300, 1'b1, -1, 0, l3);
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (dout_vld === 1'b1) begin
            found = 1'b1;
            break;
          end
        end
        got[43] = dout_vld;
        for (int i = 1; i < 44; i++) begin
          @(negedge clk);
          got[43-i] = dout_vld;
        end
      end
    join
    for (int i = 0; i < 44; i++) expv[43-i] = (i % 9 != 8);
    n_cmp++;
    if (!found || got !== expv) begin
      n_err++;
      $display("FAIL rr_idle_gaps got=%b required=%b", got, expv);
    end
    n_cmp++;
    if (gnt_order.size() != 5) begin
      n_err++;
      $display("FAIL rr_grant_count got=%0d required=5", gnt_order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (gnt_order[i] != exp_order[i]) begin
          n_err++;
          $display("FAIL rr_grant_order idx=%0d got=%0d required=%0d", i, gnt_order[i], exp_order[i]);
        end
      end
    end
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rr_drain got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    int l0, l1;
    gnt_order.delete();
    fork
      send_pkt(0, 8, 16'h4000, 1'b1, 4, 5, l0);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_pkt(1, 2, 16'h4100, 1'b1, -1, 0, l1);
      end
    join
    n_cmp++;
    if (l0 != 4) begin
      n_err++;
      $display("FAIL stall_dout_low got=%0d required=4", l0);
    end
    n_cmp++;
    if (gnt_order.size() != 2 || gnt_order[0] != 0 || gnt_order[1] != 1) begin
      n_err++;
      $display("FAIL stall_grant_order got size=%0d required 0 then 1", gnt_order.size());
    end
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_drain got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_reset_in_pad();
    int l0, l1, l2;
    send_pkt(1, 1, 16'h5555, 1'b1, -1, 0, l0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dout_vld, dout_last, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_pad_outputs got vld=%b last=%b busy=%b required 000", dout_vld, dout_last, busy);
    end
    n_cmp++;
    if (src_rdy !== 4'b0) begin
      n_err++;
      $display("FAIL rst_pad_rdy got=%b required=0000", src_rdy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    gnt_order.delete();
    fork
      send_pkt(1, 1, 16'h5100, 1'b1, -1, 0, l1);
      send_pkt(2, 1, 16'h5200, 1'b1, -1, 0, l2);
      send_pkt(0, 1, 16'h5000, 1'b1, -1, 0, l0);
    join
    n_cmp++;
    if (gnt_order.size() != 3 || gnt_order[0] != 0 || gnt_order[1] != 1 || gnt_order[2] != 2) begin
      n_err++;
      $display("FAIL rst_first_grant got first=%0d size=%0d required order 0,1,2",
               (gnt_order.size() > 0) ? gnt_order[0] : -1, gnt_order.size());
    end
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_pad_drain got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_watchdog();
    int l;
`ifdef ARB_WATCHDOG_EN
    int stalls;
    bit seen;
    beat_t e;
    send_pkt(3, 3, 16'h6000, 1'b0, -1, 0, l);
    stalls = 0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (src_rdy[3] === 1'b1 && src_vld[3] === 1'b0) stalls++;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL wdog_err got=no pulse required=pulse");
    end
    n_cmp++;
    if (stalls != 16) begin
      n_err++;
      $display("FAIL wdog_stall_cycles got=%0d required=16", stalls);
    end
    for (int i = 3; i < RATIO; i++) begin
      e.data = PADV;
      e.id   = 2'd3;
      e.last = (i == RATIO - 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_err_width got=%b required=0", err);
    end
    n_cmp++;
    if (src_rdy !== 4'b0) begin
      n_err++;
      $display("FAIL wdog_grant_drop got=%b required=0000", src_rdy);
    end
`else
    send_pkt(3, 8, 16'h6000, 1'b1, 3, 40, l);
    n_cmp++;
    if (l != 39) begin
      n_err++;
      $display("FAIL nowdog_stall_low got=%0d required=39", l);
    end
`endif
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_drain got pending=%0d busy=%b required 0 and 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      tb_vld[i]  = 1'b0;
      tb_last[i] = 1'b0;
      tb_data[i] = '0;
    end
    test_reset();
    test_full_packet();
    test_pad();
    test_round_robin();
    test_stall();
    test_reset_in_pad();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
